// File: rtl/dcache_if.sv
// dcache_if: MEM-side request/response and pmem line-transfer signals of the data cache.
interface dcache_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         dcache_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, dcache_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, dcache_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-allocate, write-through data cache with 128-bit line transfers.
module dcache #(
    parameter int NUM_SETS = 8
) (
    input logic     clk,
    input logic     rst_n,
    dcache_if.slave bus
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 12 - IW;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;
    state_t              r_state;
    logic [NUM_SETS-1:0] r_valid;
    logic [TW-1:0]       r_tag [NUM_SETS];
    logic [127:0]        r_data [NUM_SETS];
    logic [15:1]         r_addr;
    logic [15:0]         r_wdata;
    logic [1:0]          r_be;
    logic                r_write;
    logic                r_resp;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [15:0]         r_rdata;
    logic [15:0]         r_pmem_addr;
    logic [127:0]        r_pmem_wdata;
    logic [IW-1:0]       w_idx;
    logic [IW-1:0]       w_ridx;
    logic                w_hit;
    logic [127:0]        w_hit_line;
    logic [127:0]        w_hit_merge;
    logic [127:0]        w_fetch_merge;
    function automatic logic [127:0] merge(input logic [127:0] line, input logic [2:0] w,
                                           input logic [1:0] be, input logic [15:0] d);
        logic [127:0] m;
        m = line;
        if (be[0]) m[{w, 4'h0} +: 8] = d[7:0];
        if (be[1]) m[{w, 4'h8} +: 8] = d[15:8];
        return m;
    endfunction
    function automatic logic [15:0] word(input logic [127:0] line, input logic [2:0] w);
        return line[{w, 4'h0} +: 16];
    endfunction
    assign w_idx         = bus.mem_address[3+IW:4];
    assign w_ridx        = r_addr[3+IW:4];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == bus.mem_address[15:4+IW]);
    assign w_hit_line    = r_data[w_idx];
    assign w_hit_merge   = merge(w_hit_line, bus.mem_address[3:1], bus.mem_byte_enable, bus.mem_wdata);
    assign w_fetch_merge = merge(bus.pmem_rdata, r_addr[3:1], r_be, r_wdata);
    // A simultaneous read+write is handled as a write since r_write takes mem_write alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_resp       <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_rdata      <= '0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.mem_read || bus.mem_write) begin
                    r_addr      <= bus.mem_address[15:1];
                    r_write     <= bus.mem_write;
                    r_be        <= bus.mem_byte_enable;
                    r_wdata     <= bus.mem_wdata;
                    r_pmem_addr <= {bus.mem_address[15:4], 4'h0};
                    if (!w_hit) begin
                        r_pmem_read <= 1'b1;
                        r_state     <= FETCH;
                    end else if (bus.mem_write) begin
                        r_data[w_idx] <= w_hit_merge;
                        r_pmem_wdata  <= w_hit_merge;
                        r_pmem_write  <= 1'b1;
                        r_state       <= WRITE;
                    end else begin
                        r_rdata <= word(w_hit_line, bus.mem_address[3:1]);
                        r_resp  <= 1'b1;
                        r_state <= RESP;
                    end
                end
                FETCH: if (bus.pmem_resp) begin
                    r_pmem_read     <= 1'b0;
                    r_valid[w_ridx] <= 1'b1;
                    r_tag[w_ridx]   <= r_addr[15:4+IW];
                    r_data[w_ridx]  <= r_write ? w_fetch_merge : bus.pmem_rdata;
                    if (r_write) begin
                        r_pmem_wdata <= w_fetch_merge;
                        r_pmem_write <= 1'b1;
                        r_state      <= WRITE;
                    end else begin
                        r_rdata <= word(bus.pmem_rdata, r_addr[3:1]);
                        r_resp  <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WRITE: if (bus.pmem_resp) begin
                    r_pmem_write <= 1'b0;
                    r_rdata      <= word(r_pmem_wdata, r_addr[3:1]);
                    r_resp       <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.mem_rdata    = r_rdata;
    assign bus.dcache_resp  = r_resp;
    assign bus.pmem_address = r_pmem_addr;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_wdata   = r_pmem_wdata;
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache with a hand-driven pmem.
module tb_dcache;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    dcache_if bus ();
    dcache #(.NUM_SETS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    localparam logic [127:0] L1  = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;
    localparam logic [127:0] L1W = 128'h7777_6666_5555_4444_3333_BEAA_1111_0000;
    localparam logic [127:0] L2  = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;
    localparam logic [127:0] L2W = 128'hA7A7_A6A6_A5A5_A4A4_CAFE_A2A2_A1A1_A0A0;
    localparam logic [127:0] L3W = 128'h0000_0000_0000_0000_0000_0000_0000_5555;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [15:0] a, input logic rd, input logic wr,
                       input logic [1:0] be, input logic [15:0] wd);
        bus.mem_address     = a;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
    endtask
    task automatic pmem(input logic r, input logic [127:0] d);
        bus.pmem_resp  = r;
        bus.pmem_rdata = d;
    endtask
    initial begin
        rst_n = 1'b0;
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        pmem(1'b0, '0);
        tick();
        tick();
        check("rst_resp", bus.dcache_resp, 0);
        check("rst_pread", bus.pmem_read, 0);
        check("rst_pwrite", bus.pmem_write, 0);
        check("rst_rdata", bus.mem_rdata, 0);
        check("rst_paddr", bus.pmem_address, 0);
        check("rst_pwdata", bus.pmem_wdata, 0);
        rst_n = 1'b1;
        tick();
        check("idle_pread", bus.pmem_read, 0);
        // read miss 0x1234
        req(16'h1234, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t1_pread", bus.pmem_read, 1);
        check("t1_paddr", bus.pmem_address, 16'h1230);
        check("t1_pwrite", bus.pmem_write, 0);
        check("t1_noresp", bus.dcache_resp, 0);
        tick();
        check("t1_pread_hold", bus.pmem_read, 1);
        pmem(1'b1, L1);
        tick();
        pmem(1'b0, '0);
        check("t1_resp", bus.dcache_resp, 1);
        check("t1_rdata", bus.mem_rdata, 16'hBEEF);
        check("t1_pread_drop", bus.pmem_read, 0);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        check("t1_resp_pulse", bus.dcache_resp, 0);
        // read hit 0x1234
        req(16'h1234, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t2_resp", bus.dcache_resp, 1);
        check("t2_rdata", bus.mem_rdata, 16'hBEEF);
        check("t2_nopread", bus.pmem_read, 0);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        check("t2_resp_pulse", bus.dcache_resp, 0);
        // byte write hit
        req(16'h1234, 1'b0, 1'b1, 2'b01, 16'h00AA);
        tick();
        check("t3_pwrite", bus.pmem_write, 1);
        check("t3_pread", bus.pmem_read, 0);
        check("t3_paddr", bus.pmem_address, 16'h1230);
        check("t3_pwdata", bus.pmem_wdata, L1W);
        check("t3_noresp", bus.dcache_resp, 0);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        pmem(1'b1, '0);
        tick();
        pmem(1'b0, '0);
        check("t3_resp", bus.dcache_resp, 1);
        check("t3_pwrite_drop", bus.pmem_write, 0);
        tick();
        req(16'h1234, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t3_reread_resp", bus.dcache_resp, 1);
        check("t3_reread_rdata", bus.mem_rdata, 16'hBEAA);
        check("t3_reread_nopread", bus.pmem_read, 0);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        // write miss to same set, request dropped mid-transaction
        req(16'h2236, 1'b0, 1'b1, 2'b11, 16'hCAFE);
        tick();
        check("t4_pread", bus.pmem_read, 1);
        check("t4_paddr", bus.pmem_address, 16'h2230);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        pmem(1'b1, L2);
        tick();
        pmem(1'b0, '0);
        check("t4_pwrite", bus.pmem_write, 1);
        check("t4_pread_drop", bus.pmem_read, 0);
        check("t4_pwdata", bus.pmem_wdata, L2W);
        check("t4_paddr_w", bus.pmem_address, 16'h2230);
        tick();
        check("t4_pwrite_hold", bus.pmem_write, 1);
        pmem(1'b1, '0);
        tick();
        pmem(1'b0, '0);
        check("t4_resp", bus.dcache_resp, 1);
        check("t4_rdata", bus.mem_rdata, 16'hCAFE);
        tick();
        req(16'h1234, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t4_evict_miss", bus.pmem_read, 1);
        check("t4_evict_noresp", bus.dcache_resp, 0);
        pmem(1'b1, L1W);
        tick();
        pmem(1'b0, '0);
        check("t4_refill_rdata", bus.mem_rdata, 16'hBEAA);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        // reset during FETCH
        req(16'h2236, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t5_pread", bus.pmem_read, 1);
        rst_n = 1'b0;
        tick();
        check("t5_pread_drop", bus.pmem_read, 0);
        check("t5_noresp", bus.dcache_resp, 0);
        rst_n = 1'b1;
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        check("t5_noresp2", bus.dcache_resp, 0);
        req(16'h1234, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t5_miss", bus.pmem_read, 1);
        pmem(1'b1, L1W);
        tick();
        pmem(1'b0, '0);
        check("t5_resp", bus.dcache_resp, 1);
        check("t5_rdata", bus.mem_rdata, 16'hBEAA);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        // read and write together act as a write
        req(16'h0040, 1'b1, 1'b1, 2'b11, 16'h5555);
        tick();
        check("t6_pread", bus.pmem_read, 1);
        check("t6_paddr", bus.pmem_address, 16'h0040);
        pmem(1'b1, '0);
        tick();
        pmem(1'b0, '0);
        check("t6_pwrite", bus.pmem_write, 1);
        check("t6_pwdata", bus.pmem_wdata, L3W);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        pmem(1'b1, '0);
        tick();
        pmem(1'b0, '0);
        check("t6_resp", bus.dcache_resp, 1);
        tick();
        req(16'h0040, 1'b1, 1'b0, 2'b11, 16'h0);
        tick();
        check("t6_reread_resp", bus.dcache_resp, 1);
        check("t6_reread_rdata", bus.mem_rdata, 16'h5555);
        check("t6_reread_nopread", bus.pmem_read, 0);
        req(16'h0, 1'b0, 1'b0, 2'b00, 16'h0);
        tick();
        tick();
        tick();
        check("end_idle_resp", bus.dcache_resp, 0);
        check("end_idle_pmem", {bus.pmem_read, bus.pmem_write}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
